// File: rtl/pcie_interrupt_arbiter.sv
// Merges Rx/Tx level interrupt requests into MSI handshakes on the endpoint cfg_interrupt port.
// Round-robin between the two sources; a programmable idle gap separates consecutive MSIs.
module pcie_interrupt_arbiter #(
    parameter logic [7:0] RX_VECTOR = 8'h00,
    parameter logic [7:0] TX_VECTOR = 8'h01,
    parameter int         HOLDOFF_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_send_interrupt,
    input  logic                 tx_send_interrupt,
    input  logic                 interrupts_enabled,
    input  logic [HOLDOFF_W-1:0] holdoff,
    input  logic                 cfg_interrupt_msienable,
    input  logic                 cfg_interrupt_rdy_n,
    output logic                 cfg_interrupt_n,
    output logic [7:0]           cfg_interrupt_di,
    output logic [31:0]          irq_count
);

    // state   | meaning
    // IDLE    | no MSI outstanding, waiting for an enabled pending source
    // REQ     | cfg_interrupt_n low, waiting for the endpoint to acknowledge
    // HOLDOFF | enforcing the idle gap after an acknowledge
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_REQ     = 3'b010,
        ST_HOLDOFF = 3'b100
    } state_t;

    localparam logic SRC_RX = 1'b0;
    localparam logic SRC_TX = 1'b1;

    state_t                 state_q, state_d;
    logic                   rx_prev_q, rx_prev_d;
    logic                   tx_prev_q, tx_prev_d;
    logic                   rx_pend_q, rx_pend_d;
    logic                   tx_pend_q, tx_pend_d;
    logic                   last_q, last_d;
    logic                   grant_q, grant_d;
    logic                   irq_n_q, irq_n_d;
    logic [7:0]             di_q, di_d;
    logic [31:0]            irq_count_q, irq_count_d;
    logic [HOLDOFF_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic rx_rise, tx_rise;
    logic rx_clr, tx_clr;
    logic ack;
    logic go;
    logic sel;

    always_comb begin
        rx_rise = rx_send_interrupt && !rx_prev_q;
        tx_rise = tx_send_interrupt && !tx_prev_q;
        ack     = (state_q == ST_REQ) && !cfg_interrupt_rdy_n;

        // A granted source keeps its flag through REQ even if it drops; the ack clears it.
        rx_clr = (ack && grant_q == SRC_RX) ||
                 (!rx_send_interrupt && !(state_q == ST_REQ && grant_q == SRC_RX));
        tx_clr = (ack && grant_q == SRC_TX) ||
                 (!tx_send_interrupt && !(state_q == ST_REQ && grant_q == SRC_TX));

        rx_pend_d = rx_rise || (rx_pend_q && !rx_clr);
        tx_pend_d = tx_rise || (tx_pend_q && !tx_clr);
        rx_prev_d = rx_send_interrupt;
        tx_prev_d = tx_send_interrupt;

        go  = interrupts_enabled && cfg_interrupt_msienable && (rx_pend_q || tx_pend_q);
        sel = (rx_pend_q && tx_pend_q) ? !last_q : tx_pend_q;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        irq_n_d     = irq_n_q;
        di_d        = di_q;
        irq_count_d = irq_count_q;
        hold_cnt_d  = hold_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    grant_d = sel;
                    di_d    = (sel == SRC_TX) ? TX_VECTOR : RX_VECTOR;
                    irq_n_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    irq_n_d     = 1'b1;
                    last_d      = grant_q;
                    irq_count_d = irq_count_q + 32'd1;
                    hold_cnt_d  = holdoff;
                    state_d     = (holdoff == '0) ? ST_IDLE : ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                hold_cnt_d = hold_cnt_q - HOLDOFF_W'(1);
                if (hold_cnt_q <= HOLDOFF_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                irq_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rx_prev_q   <= 1'b0;
            tx_prev_q   <= 1'b0;
            rx_pend_q   <= 1'b0;
            tx_pend_q   <= 1'b0;
            last_q      <= SRC_TX;
            grant_q     <= SRC_RX;
            irq_n_q     <= 1'b1;
            di_q        <= 8'h00;
            irq_count_q <= 32'd0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rx_prev_q   <= rx_prev_d;
            tx_prev_q   <= tx_prev_d;
            rx_pend_q   <= rx_pend_d;
            tx_pend_q   <= tx_pend_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            irq_n_q     <= irq_n_d;
            di_q        <= di_d;
            irq_count_q <= irq_count_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign cfg_interrupt_n  = irq_n_q;
    assign cfg_interrupt_di = di_q;
    assign irq_count        = irq_count_q;

endmodule

// File: tb/tb_pcie_interrupt_arbiter.sv
// Bench for pcie_interrupt_arbiter: directed scenarios with literal checks plus a
// randomized run, all compared each cycle against a behavioural MSI model.
module tb_pcie_interrupt_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_send_interrupt;
    logic        tx_send_interrupt;
    logic        interrupts_enabled;
    logic [15:0] holdoff;
    logic        cfg_interrupt_msienable;
    logic        cfg_interrupt_rdy_n;
    logic        cfg_interrupt_n;
    logic [7:0]  cfg_interrupt_di;
    logic [31:0] irq_count;

    pcie_interrupt_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .rx_send_interrupt       (rx_send_interrupt),
        .tx_send_interrupt       (tx_send_interrupt),
        .interrupts_enabled      (interrupts_enabled),
        .holdoff                 (holdoff),
        .cfg_interrupt_msienable (cfg_interrupt_msienable),
        .cfg_interrupt_rdy_n     (cfg_interrupt_rdy_n),
        .cfg_interrupt_n         (cfg_interrupt_n),
        .cfg_interrupt_di        (cfg_interrupt_di),
        .irq_count               (irq_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an outstanding request flag, a remaining gap count, and per-source pending flags.
    bit          m_prev [2];
    bit          m_pend [2];
    bit          m_req   = 0;
    bit          m_n     = 1;
    bit          m_grant = 0;
    bit          m_last  = 1;
    int unsigned m_gap   = 0;
    logic [7:0]  m_di    = 8'h00;
    logic [31:0] m_count = 32'd0;

    always @(posedge clk) begin : model
        bit src [2];
        bit np  [2];
        bit ack;
        bit go;
        bit pick;
        src[0] = rx_send_interrupt;
        src[1] = tx_send_interrupt;
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                m_prev[s] = 0;
                m_pend[s] = 0;
            end
            m_req = 0; m_n = 1; m_grant = 0; m_last = 1; m_gap = 0;
            m_di = 8'h00; m_count = 32'd0;
        end else begin
            ack = m_req && !cfg_interrupt_rdy_n;
            go  = interrupts_enabled && cfg_interrupt_msienable && (m_pend[0] || m_pend[1]);
            for (int s = 0; s < 2; s++) begin
                if (src[s] && !m_prev[s])
                    np[s] = 1;
                else if (ack && int'(m_grant) == s)
                    np[s] = 0;
                else if (!src[s] && !(m_req && int'(m_grant) == s))
                    np[s] = 0;
                else
                    np[s] = m_pend[s];
            end
            if (m_req) begin
                if (ack) begin
                    m_req   = 0;
                    m_n     = 1;
                    m_last  = m_grant;
                    m_count = m_count + 32'd1;
                    m_gap   = int'(holdoff);
                end
            end else if (m_gap > 0) begin
                m_gap = m_gap - 1;
            end else if (go) begin
                pick    = (m_pend[0] && m_pend[1]) ? !m_last : m_pend[1];
                m_grant = pick;
                m_di    = pick ? 8'h01 : 8'h00;
                m_req   = 1;
                m_n     = 0;
            end
            for (int s = 0; s < 2; s++) begin
                m_pend[s] = np[s];
                m_prev[s] = src[s];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model irq_n", {31'd0, cfg_interrupt_n}, {31'd0, m_n});
            chk("model di", {24'd0, cfg_interrupt_di}, {24'd0, m_di});
            chk("model count", irq_count, m_count);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_one();
        cfg_interrupt_rdy_n = 1'b0;
        tick(1);
        cfg_interrupt_rdy_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        rx_send_interrupt = 1'b0;
        tx_send_interrupt = 1'b0;
        interrupts_enabled = 1'b1;
        cfg_interrupt_msienable = 1'b1;
        holdoff = 16'd0;
        cfg_interrupt_rdy_n = 1'b1;
        tick(3);
        chk("reset irq_n", {31'd0, cfg_interrupt_n}, 32'd1);
        chk("reset di", {24'd0, cfg_interrupt_di}, 32'd0);
        chk("reset count", irq_count, 32'd0);
        chk_en = 1;
        reset = 1'b0;
        tick(2);

        // single Tx request, 2-cycle latency, no repeat while held high
        tx_send_interrupt = 1'b1;
        tick(1);
        chk("tx lat1 irq_n", {31'd0, cfg_interrupt_n}, 32'd1);
        tick(1);
        chk("tx lat2 irq_n", {31'd0, cfg_interrupt_n}, 32'd0);
        chk("tx di", {24'd0, cfg_interrupt_di}, 32'h01);
        tick(2);
        chk("tx held irq_n", {31'd0, cfg_interrupt_n}, 32'd0);
        ack_one();
        chk("tx ack irq_n", {31'd0, cfg_interrupt_n}, 32'd1);
        chk("tx count", irq_count, 32'd1);
        tick(10);
        chk("tx no repeat", {31'd0, cfg_interrupt_n}, 32'd1);
        tx_send_interrupt = 1'b0;
        tick(2);

        // simultaneous edges: Rx wins the tie, Tx follows after one idle cycle
        rx_send_interrupt = 1'b1;
        tx_send_interrupt = 1'b1;
        tick(2);
        chk("tie first di", {24'd0, cfg_interrupt_di}, 32'h00);
        chk("tie first irq_n", {31'd0, cfg_interrupt_n}, 32'd0);
        ack_one();
        chk("tie gap irq_n", {31'd0, cfg_interrupt_n}, 32'd1);
        tick(1);
        chk("tie second irq_n", {31'd0, cfg_interrupt_n}, 32'd0);
        chk("tie second di", {24'd0, cfg_interrupt_di}, 32'h01);
        ack_one();
        chk("tie count", irq_count, 32'd3);
        rx_send_interrupt = 1'b0;
        tx_send_interrupt = 1'b0;
        tick(2);

        // holdoff of 100; a mid-gap holdoff change must not shorten the gap
        holdoff = 16'd100;
        rx_send_interrupt = 1'b1;
        tick(2);
        chk("hold rx irq_n", {31'd0, cfg_interrupt_n}, 32'd0);
        ack_one();
        tick(4);
        tx_send_interrupt = 1'b1;
        tick(45);
        holdoff = 16'd7;
        tick(51);
        chk("hold A+100 irq_n", {31'd0, cfg_interrupt_n}, 32'd1);
        tick(1);
        chk("hold A+101 irq_n", {31'd0, cfg_interrupt_n}, 32'd0);
        chk("hold tx di", {24'd0, cfg_interrupt_di}, 32'h01);
        ack_one();
        rx_send_interrupt = 1'b0;
        tx_send_interrupt = 1'b0;
        tick(12);
        chk("hold count", irq_count, 32'd5);

        // withdrawal during REQ, then a stale pulse while disabled
        holdoff = 16'd0;
        tx_send_interrupt = 1'b1;
        tick(2);
        chk("wd irq_n", {31'd0, cfg_interrupt_n}, 32'd0);
        interrupts_enabled = 1'b0;
        tx_send_interrupt = 1'b0;
        tick(5);
        chk("wd held irq_n", {31'd0, cfg_interrupt_n}, 32'd0);
        ack_one();
        chk("wd ack irq_n", {31'd0, cfg_interrupt_n}, 32'd1);
        tick(3);
        rx_send_interrupt = 1'b1;
        tick(1);
        rx_send_interrupt = 1'b0;
        tick(2);
        interrupts_enabled = 1'b1;
        tick(5);
        chk("stale irq_n", {31'd0, cfg_interrupt_n}, 32'd1);
        chk("stale count", irq_count, 32'd6);

        // reset while in REQ with the source held high across it
        rx_send_interrupt = 1'b1;
        tick(2);
        chk("rst pre irq_n", {31'd0, cfg_interrupt_n}, 32'd0);
        reset = 1'b1;
        tick(1);
        chk("rst irq_n", {31'd0, cfg_interrupt_n}, 32'd1);
        chk("rst count", irq_count, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("rst post1 irq_n", {31'd0, cfg_interrupt_n}, 32'd1);
        tick(1);
        chk("rst post2 irq_n", {31'd0, cfg_interrupt_n}, 32'd0);
        ack_one();
        chk("rst count after", irq_count, 32'd1);
        rx_send_interrupt = 1'b0;
        tick(3);

        // counter wrap
        @(posedge clk);
        #2;
        force dut.irq_count_q = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        @(posedge clk);
        #2;
        release dut.irq_count_q;
        @(negedge clk);
        tx_send_interrupt = 1'b1;
        tick(2);
        chk("wrap irq_n", {31'd0, cfg_interrupt_n}, 32'd0);
        ack_one();
        chk("wrap count", irq_count, 32'd0);
        tx_send_interrupt = 1'b0;
        tick(3);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rx_send_interrupt = ~rx_send_interrupt;
            if ($urandom_range(0, 7) == 0) tx_send_interrupt = ~tx_send_interrupt;
            interrupts_enabled      = ($urandom_range(0, 15) != 0);
            cfg_interrupt_msienable = ($urandom_range(0, 31) != 0);
            cfg_interrupt_rdy_n     = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 49) == 0) holdoff = 16'($urandom_range(0, 6));
            reset = ($urandom_range(0, 299) == 0);
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
